// File: rtl/drainer_scheduler.sv
// Clock-enable scheduler for the flip-flop drainer load: continuous, burst, or
// vblank-gated pulse trains at a programmable prescaled rate.
module drainer_scheduler #(
   parameter int unsigned PRESCALE_W = 16,
   parameter int unsigned BURST_W    = 16,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [BURST_W-1:0]    burst_on,
   input  logic [BURST_W-1:0]    burst_off,
   input  logic                  vblank_async,
   input  logic                  count_clr,
   output logic                  drain_en,
   output logic [1:0]            phase,
   output logic                  busy,
   output logic [CNT_W-1:0]      pulse_count
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_OFF = 2'd2, ST_WAIT = 2'd3} state_t;
   typedef enum logic [1:0] {M_CONT = 2'd0, M_BURST = 2'd1, M_BLANK = 2'd2, M_OFF = 2'd3} mode_t;

   state_t                  state_q, state_d;
   mode_t                   mode_q, mode_d;
   logic [PRESCALE_W-1:0]   pre_q, pre_d;
   logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
   logic [BURST_W-1:0]      on_q, on_d;
   logic [BURST_W-1:0]      off_q, off_d;
   logic [BURST_W-1:0]      bcnt_q, bcnt_d;
   logic [BURST_W-1:0]      ocnt_q, ocnt_d;
   logic                    vs1_q, vs2_q;
   logic                    drain_q, drain_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         mode_q  <= M_CONT;
         pre_q   <= '0;
         pcnt_q  <= '0;
         on_q    <= '0;
         off_q   <= '0;
         bcnt_q  <= '0;
         ocnt_q  <= '0;
         vs1_q   <= 1'b0;
         vs2_q   <= 1'b0;
         drain_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pre_q   <= pre_d;
         pcnt_q  <= pcnt_d;
         on_q    <= on_d;
         off_q   <= off_d;
         bcnt_q  <= bcnt_d;
         ocnt_q  <= ocnt_d;
         vs1_q   <= vblank_async;
         vs2_q   <= vs1_q;
         drain_q <= drain_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pre_d   = pre_q;
      pcnt_d  = pcnt_q;
      on_d    = on_q;
      off_d   = off_q;
      bcnt_d  = bcnt_q;
      ocnt_d  = ocnt_q;
      drain_d = 1'b0;

      if (!enable) begin
         state_d = ST_IDLE;
         pcnt_d  = '0;
         bcnt_d  = '0;
         ocnt_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (mode_t'(mode) != M_OFF) begin
                  mode_d  = mode_t'(mode);
                  pre_d   = prescale;
                  on_d    = (burst_on == '0) ? BURST_W'(1) : burst_on;
                  off_d   = burst_off;
                  pcnt_d  = '0;
                  bcnt_d  = '0;
                  ocnt_d  = '0;
                  state_d = (mode_t'(mode) == M_BLANK) ? ST_WAIT : ST_ON;
               end
            end
            ST_ON: begin
               // Falling synced vblank takes priority, swallowing any pulse due now.
               if (mode_q == M_BLANK && !vs2_q) begin
                  state_d = ST_WAIT;
                  pcnt_d  = '0;
               end else if (pcnt_q == pre_q) begin
                  drain_d = 1'b1;
                  pcnt_d  = '0;
                  if (mode_q == M_BURST) begin
                     if (bcnt_q == on_q - BURST_W'(1)) begin
                        bcnt_d = '0;
                        if (off_q != '0) begin
                           state_d = ST_OFF;
                           ocnt_d  = '0;
                        end
                     end else begin
                        bcnt_d = bcnt_q + BURST_W'(1);
                     end
                  end
               end else begin
                  pcnt_d = pcnt_q + PRESCALE_W'(1);
               end
            end
            ST_OFF: begin
               if (ocnt_q == off_q - BURST_W'(1)) begin
                  state_d = ST_ON;
                  ocnt_d  = '0;
                  pcnt_d  = '0;
               end else begin
                  ocnt_d = ocnt_q + BURST_W'(1);
               end
            end
            ST_WAIT: begin
               if (vs2_q) begin
                  state_d = ST_ON;
                  pcnt_d  = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      cnt_d = cnt_q;
      if (count_clr)
         cnt_d = '0;
      else if (drain_d && cnt_q != '1)
         cnt_d = cnt_q + CNT_W'(1);
   end

   assign drain_en    = drain_q;
   assign phase       = state_q;
   assign busy        = (state_q != ST_IDLE);
   assign pulse_count = cnt_q;

endmodule
